// File: rtl/adxl345_spi_responder.sv
// adxl345_spi_responder
//   Device-side model of the ADXL345 SPI register interface (SPI mode 3, 16-bit frames,
//   MSB first: R/nW, MB, addr[5:0], data[7:0]). All SPI inputs are oversampled with clk.
// Ports:
//   clk, rst                    system clock (>= 8x SPI_CLK), async active-high reset
//   SPI_CLK/SPI_CSN/SPI_SDI     serial link from the initiator; SPI_SDO serial data back
//   sample_valid, sample_x/y/z  host strobe loading data registers 0x32-0x37
//   wr_valid, wr_addr, wr_data  one-cycle report of each committed register write
//   data_ready                  INT_SOURCE bit 7
//   busy                        synchronised chip select is low
// Build option: define ADXL345_SPI_RESP_BURST_EN to honour the MB bit (multi-byte transfers
//   with auto-incrementing address). Without it MB is ignored and frames end after 16 bits.
module adxl345_spi_responder #(
  parameter logic [7:0]  DEVID       = 8'hE5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  BW_RATE_RST = 8'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SPI_CLK,
  input  logic        SPI_CSN,
  input  logic        SPI_SDI,
  output logic        SPI_SDO,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic        wr_valid,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        data_ready,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StDone} state_e;
  state_e state_q, state_d;

  // Input synchronisers; the extra prev flops give the two samples used for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '1;
      csn_sync_q  <= '1;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b1;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], SPI_CSN};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], SPI_SDI};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, csn_s, sdi_s;
  logic sclk_rise, sclk_fall, csn_fall, csn_rise;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~csn_s & sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~csn_s & ~sclk_s & sclk_prev_q;
  assign csn_fall  = csn_prev_q & ~csn_s;
  assign csn_rise  = ~csn_prev_q & csn_s;

  logic [4:0]  bit_cnt_q;
  logic [6:0]  rx_q;
  logic [7:0]  tx_q;
  logic [5:0]  addr_q;
  logic [7:0]  cfg_q [6'h1D:6'h31];
  logic [47:0] data_q, pend_q;
  logic        pend_valid_q, data_ready_q, data_ready_d, rd_src_q;
  logic        sdo_q, sdo_d;
  logic        wr_valid_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  // Byte currently completing on this rise (7 shifted bits plus the live SDI sample).
  logic [7:0] cmd_byte;
  logic       byte_done, burst;
  assign cmd_byte  = {rx_q, sdi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 5'd15);

`ifdef ADXL345_SPI_RESP_BURST_EN
  logic mb_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_q <= 1'b0;
    end else if ((state_q == StCmd) && sclk_rise && (bit_cnt_q == 5'd7)) begin
      mb_q <= cmd_byte[6];
    end
  end
  assign burst = mb_q;
`else
  logic unused_mb;
  assign unused_mb = cmd_byte[6];
  assign burst     = 1'b0;
`endif

  function automatic logic is_writable(input logic [5:0] a);
    return ((a >= 6'h1D) && (a <= 6'h2F)) || (a == 6'h31);
  endfunction

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: decoded control strobes.
  logic shift_in, latch_cmd, commit, tx_shift, reload, data_end;
  always_comb begin
    shift_in  = 1'b0;
    latch_cmd = 1'b0;
    commit    = 1'b0;
    tx_shift  = 1'b0;
    reload    = 1'b0;
    data_end  = 1'b0;
    case (state_q)
      StCmd: begin
        shift_in  = sclk_rise;
        latch_cmd = sclk_rise && (bit_cnt_q == 5'd7);
      end
      StWdata: begin
        shift_in = sclk_rise;
        data_end = byte_done;
        commit   = byte_done && is_writable(addr_q);
      end
      StRdata: begin
        tx_shift = sclk_fall;
        data_end = byte_done;
        reload   = byte_done && burst;
      end
      default: ;
    endcase
    busy = ~csn_s;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (csn_rise) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (csn_fall) state_d = StCmd;
        StCmd:   if (latch_cmd) state_d = cmd_byte[7] ? StRdata : StWdata;
        StWdata,
        StRdata: if (data_end && !burst) state_d = StDone;
        StDone:  ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Read mux: the commanded address on the command byte, the next address on a burst reload.
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_load;
  assign rd_addr = latch_cmd ? cmd_byte[5:0] : addr_q + 6'd1;
  assign rd_load = (latch_cmd && cmd_byte[7]) || reload;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      6'h00:   rd_data = DEVID;
      6'h30:   rd_data = {data_ready_q, 7'b0};
      6'h32:   rd_data = data_q[7:0];
      6'h33:   rd_data = data_q[15:8];
      6'h34:   rd_data = data_q[23:16];
      6'h35:   rd_data = data_q[31:24];
      6'h36:   rd_data = data_q[39:32];
      6'h37:   rd_data = data_q[47:40];
      default: if (is_writable(rd_addr)) rd_data = cfg_q[rd_addr];
    endcase
  end

  always_comb begin
    sdo_d = sdo_q;
    if (tx_shift) sdo_d = tx_q[7];
    if (state_d != StRdata) sdo_d = 1'b1;
  end

  // Frame datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      sdo_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (csn_rise) begin
        bit_cnt_q <= '0;
      end else if (sclk_rise && (state_q inside {StCmd, StWdata, StRdata})) begin
        if (data_end && burst)          bit_cnt_q <= 5'd8;
        else if (bit_cnt_q != 5'd16)    bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (shift_in) rx_q <= cmd_byte[6:0];
      if (rd_load)       tx_q <= rd_data;
      else if (tx_shift) tx_q <= {tx_q[6:0], 1'b0};
      if (latch_cmd)               addr_q <= cmd_byte[5:0];
      else if (data_end && burst)  addr_q <= addr_q + 6'd1;
      sdo_q      <= sdo_d;
      wr_valid_q <= commit;
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= cmd_byte;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 'h1D; i <= 'h31; i++) begin
        cfg_q[6'(i)] <= (i == 'h2C) ? BW_RATE_RST : 8'h00;
      end
    end else if (commit) begin
      cfg_q[addr_q] <= cmd_byte;
    end
  end

  // Samples arriving mid-transaction are parked until CSN rises so a frame never reads torn data.
  always_comb begin
    data_ready_d = data_ready_q;
    if (csn_rise && rd_src_q) data_ready_d = 1'b0;
    if ((csn_rise && pend_valid_q) || (sample_valid && csn_s)) data_ready_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      data_ready_q <= 1'b0;
      rd_src_q     <= 1'b0;
    end else begin
      if (csn_rise && pend_valid_q) begin
        data_q       <= pend_q;
        pend_valid_q <= 1'b0;
      end
      if (sample_valid) begin
        if (csn_s) begin
          data_q <= {sample_z, sample_y, sample_x};
        end else begin
          pend_q       <= {sample_z, sample_y, sample_x};
          pend_valid_q <= 1'b1;
        end
      end
      if (csn_rise)                             rd_src_q <= 1'b0;
      else if (rd_load && (rd_addr == 6'h30))   rd_src_q <= 1'b1;
      data_ready_q <= data_ready_d;
    end
  end

  assign SPI_SDO    = sdo_q;
  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign data_ready = data_ready_q;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
module tb_adxl345_spi_responder;
  localparam int HALF = 8;  // clk cycles per SPI_CLK half period

  logic        clk = 1'b0;
  logic        rst;
  logic        SPI_CLK, SPI_CSN, SPI_SDI, SPI_SDO;
  logic        sample_valid;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        data_ready, busy;

  always #5 clk = ~clk;

  adxl345_spi_responder dut (
    .clk          (clk),
    .rst          (rst),
    .SPI_CLK      (SPI_CLK),
    .SPI_CSN      (SPI_CSN),
    .SPI_SDI      (SPI_SDI),
    .SPI_SDO      (SPI_SDO),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .data_ready   (data_ready),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int         wr_cnt = 0;
  logic [5:0] last_wa = '0;
  logic [7:0] last_wd = '0;
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
  end

  // Reference model of the register map.
  logic [7:0] m_cfg [64];
  logic [7:0] m_data [6];
  logic       m_dr;

  function automatic bit m_writable(input logic [5:0] a);
    return (a >= 6'h1D && a <= 6'h2F) || a == 6'h31;
  endfunction

  function automatic logic [7:0] m_read(input logic [5:0] a);
    int idx;
    idx = int'(a) - 'h32;
    if (a == 6'h00) return 8'hE5;
    if (a == 6'h30) return {m_dr, 7'b0};
    if (idx >= 0 && idx < 6) return m_data[idx];
    if (m_writable(a)) return m_cfg[a];
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_cfg[i] = 8'h00;
    m_cfg[6'h2C] = 8'h0A;
    for (int i = 0; i < 6; i++) m_data[i] = 8'h00;
    m_dr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  logic [15:0] inj_x, inj_y, inj_z;

  task automatic spi_bit(input logic b, input bit inject, output logic sdo);
    SPI_CLK = 1'b0;
    SPI_SDI = b;
    if (inject) begin
      sample_valid = 1'b1;
      sample_x = inj_x;
      sample_y = inj_y;
      sample_z = inj_z;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (HALF - 1) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    SPI_CLK = 1'b1;
    sdo = SPI_SDO;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [63:0] mosi, input int nbits, input int inj_bit,
                          output logic [63:0] miso);
    logic s;
    miso = '0;
    SPI_CSN = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mosi[63-i], i == inj_bit, s);
      miso = {miso[62:0], s};
    end
    SPI_CSN = 1'b1;
    SPI_SDI = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_read(input logic [5:0] a);
    logic [63:0] miso;
    logic [7:0]  exp;
    exp = m_read(a);
    spi_xfer({2'b10, a, 56'h0}, 16, -1, miso);
    chk($sformatf("read %02h", a), {56'h0, miso[7:0]}, {56'h0, exp});
    if (a == 6'h30) m_dr = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    logic [63:0] miso;
    int          c0;
    c0 = wr_cnt;
    spi_xfer({2'b00, a, d, 48'h0}, 16, -1, miso);
    chk($sformatf("write %02h sdo idle", a), {48'h0, miso[15:0]}, 64'hFFFF);
    chk($sformatf("write %02h pulses", a), 64'(wr_cnt - c0), 64'(m_writable(a)));
    if (m_writable(a)) begin
      chk($sformatf("write %02h wr_addr/data", a), {50'h0, last_wa, last_wd}, {50'h0, a, d});
      m_cfg[a] = d;
    end
  endtask

  task automatic do_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_valid = 1'b1;
    sample_x = x;
    sample_y = y;
    sample_z = z;
    @(negedge clk);
    sample_valid = 1'b0;
    m_data[0] = x[7:0]; m_data[1] = x[15:8];
    m_data[2] = y[7:0]; m_data[3] = y[15:8];
    m_data[4] = z[7:0]; m_data[5] = z[15:8];
    m_dr = 1'b1;
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  exp_byte;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[19];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] miso;
    logic        s;
    int          c0;

    rst = 1'b1; SPI_CLK = 1'b1; SPI_CSN = 1'b1; SPI_SDI = 1'b0;
    sample_valid = 1'b0; sample_x = '0; sample_y = '0; sample_z = '0;
    inj_x = '0; inj_y = '0; inj_z = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("reset SPI_SDO", 64'(SPI_SDO), 64'h1);
    chk("reset wr_valid", 64'(wr_valid), 64'h0);
    chk("reset wr_addr", 64'(wr_addr), 64'h0);
    chk("reset wr_data", 64'(wr_data), 64'h0);
    chk("reset data_ready", 64'(data_ready), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);

    SPI_CSN = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy with CSN low", 64'(busy), 64'h1);
    SPI_CSN = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy after CSN high", 64'(busy), 64'h0);

    // Single-frame vectors from reset state; write frames must keep SDO high.
    vecs[0]  = '{16'h8000, 8'hE5, 0};
    vecs[1]  = '{16'hC000, 8'hE5, 0};
    vecs[2]  = '{16'hAC00, 8'h0A, 0};
    vecs[3]  = '{16'h2D08, 8'hFF, 1};
    vecs[4]  = '{16'hAD00, 8'h08, 0};
    vecs[5]  = '{16'h32AA, 8'hFF, 0};
    vecs[6]  = '{16'hB200, 8'h00, 0};
    vecs[7]  = '{16'h3155, 8'hFF, 1};
    vecs[8]  = '{16'hB100, 8'h55, 0};
    vecs[9]  = '{16'h1D7F, 8'hFF, 1};
    vecs[10] = '{16'h9D00, 8'h7F, 0};
    vecs[11] = '{16'h2FC3, 8'hFF, 1};
    vecs[12] = '{16'hAF00, 8'hC3, 0};
    vecs[13] = '{16'h3003, 8'hFF, 0};
    vecs[14] = '{16'hB000, 8'h00, 0};
    vecs[15] = '{16'h1C44, 8'hFF, 0};
    vecs[16] = '{16'h9C00, 8'h00, 0};
    vecs[17] = '{16'h3F99, 8'hFF, 0};
    vecs[18] = '{16'hBF00, 8'h00, 0};
    for (int v = 0; v < 19; v++) begin
      c0 = wr_cnt;
      spi_xfer({vecs[v].frame, 48'h0}, 16, -1, miso);
      chk($sformatf("vec%0d data", v), {56'h0, miso[7:0]}, {56'h0, vecs[v].exp_byte});
      chk($sformatf("vec%0d pulses", v), 64'(wr_cnt - c0), 64'(vecs[v].exp_pulses));
      if (vecs[v].exp_pulses == 1)
        chk($sformatf("vec%0d wr_addr/data", v), {50'h0, last_wa, last_wd},
            {50'h0, vecs[v].frame[13:0]});
      if (!vecs[v].frame[15] && m_writable(vecs[v].frame[13:8]))
        m_cfg[vecs[v].frame[13:8]] = vecs[v].frame[7:0];
    end

    // Sample load with CSN idle.
    do_sample(16'h1234, 16'hABCD, 16'h00FF);
    chk("data_ready after sample", 64'(data_ready), 64'h1);
    for (int a = 'h32; a <= 'h37; a++) do_read(6'(a));
    chk("sample bytes", {16'h0, m_data[0], m_data[1], m_data[2], m_data[3], m_data[4], m_data[5]},
        64'h3412CDABFF00);
    do_read(6'h30);
    chk("data_ready cleared by 0x30 read", 64'(data_ready), 64'h0);

    // Sample arriving mid-read must not tear the frame.
    inj_x = 16'h5678; inj_y = 16'h1111; inj_z = 16'h2222;
    spi_xfer({8'hB3, 56'h0}, 16, 4, miso);
    chk("mid-frame old byte", {56'h0, miso[7:0]}, 64'h12);
    chk("mid-frame data_ready", 64'(data_ready), 64'h1);
    m_data[0] = 8'h78; m_data[1] = 8'h56; m_data[2] = 8'h11; m_data[3] = 8'h11;
    m_data[4] = 8'h22; m_data[5] = 8'h22; m_dr = 1'b1;
    do_read(6'h33);

    // Set and clear of data_ready on the same CSN rise: set wins.
    inj_x = 16'h0102; inj_y = 16'h0304; inj_z = 16'h0506;
    spi_xfer({8'hB0, 56'h0}, 16, 10, miso);
    chk("0x30 read with pending sample", {56'h0, miso[7:0]}, 64'h80);
    chk("set wins over clear", 64'(data_ready), 64'h1);
    m_data[0] = 8'h02; m_data[1] = 8'h01; m_data[2] = 8'h04; m_data[3] = 8'h03;
    m_data[4] = 8'h06; m_data[5] = 8'h05;
    do_read(6'h32);
    do_read(6'h30);
    chk("data_ready cleared again", 64'(data_ready), 64'h0);

    // Aborted write after 12 bits.
    c0 = wr_cnt;
    spi_xfer({8'h2C, 8'h55, 48'h0}, 12, -1, miso);
    chk("abort pulses", 64'(wr_cnt - c0), 64'h0);
    do_read(6'h2C);

`ifdef ADXL345_SPI_RESP_BURST_EN
    do_sample(16'h1234, 16'hABCD, 16'h00FF);
    spi_xfer({8'hF2, 56'h0}, 56, -1, miso);
    chk("burst read 0x32..0x37", {16'h0, miso[47:0]},
        {16'h0, m_data[0], m_data[1], m_data[2], m_data[3], m_data[4], m_data[5]});
    c0 = wr_cnt;
    spi_xfer({8'h6D, 8'h11, 8'h22, 40'h0}, 24, -1, miso);
    chk("burst write pulses", 64'(wr_cnt - c0), 64'h2);
    chk("burst write last", {50'h0, last_wa, last_wd}, {50'h0, 6'h2E, 8'h22});
    m_cfg[6'h2D] = 8'h11; m_cfg[6'h2E] = 8'h22;
    do_read(6'h2D);
    do_read(6'h2E);
`else
    spi_xfer({8'h80, 56'h0}, 24, -1, miso);
    chk("extra clocks keep SDO high", {40'h0, miso[23:0]}, {40'h0, 24'hFFE5FF});
    c0 = wr_cnt;
    spi_xfer({8'h6D, 8'h11, 8'h22, 40'h0}, 24, -1, miso);
    chk("MB ignored write pulses", 64'(wr_cnt - c0), 64'h1);
    chk("MB ignored write", {50'h0, last_wa, last_wd}, {50'h0, 6'h2D, 8'h11});
    m_cfg[6'h2D] = 8'h11;
    do_read(6'h2E);
`endif

    // Randomised traffic against the model.
    for (int k = 0; k < 40; k++) begin
      int          op;
      logic [5:0]  a;
      logic [7:0]  d;
      op = $urandom_range(0, 2);
      a  = 6'($urandom_range(0, 63));
      d  = 8'($urandom);
      case (op)
        0: do_write(a, d);
        1: do_read(a);
        default: do_sample(16'($urandom), 16'($urandom), 16'($urandom));
      endcase
      chk("random data_ready", 64'(data_ready), 64'(m_dr));
    end

    // Reset asserted while a read of 0x2C is shifting out.
    do_sample(16'hBEEF, 16'hCAFE, 16'hF00D);
    do_write(6'h2D, 8'h5A);
    SPI_CSN = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 9; i++) spi_bit(1'(16'hAC00 >> (15 - i)), 1'b0, s);
    SPI_CLK = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("sdo before reset", 64'(SPI_SDO), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset mid-frame SDO", 64'(SPI_SDO), 64'h1);
    chk("reset mid-frame data_ready", 64'(data_ready), 64'h0);
    chk("reset mid-frame wr_addr", 64'(wr_addr), 64'h0);
    SPI_CLK = 1'b1;
    SPI_CSN = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    m_reset();
    do_read(6'h2D);
    do_read(6'h2C);
    do_read(6'h32);
    do_read(6'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adxl345_spi_responder.md
Name: adxl345_spi_responder

Overview:
- SPI mode-3 responder that models the ADXL345 register interface from the device side.
- Samples SPI_CLK, SPI_CSN and SPI_SDI with clk, decodes 16-bit read and write frames, and serves a 64-entry register map.
- Host logic loads the X/Y/Z data registers, and the block reports register writes.
- Used in simulation and FPGA-in-loop benches as the far end of the accelerometer SPI link.

Parameters:
- DEVID, 8'hE5, value returned at address 0x00.
- SYNC_STAGES, 2, synchroniser depth on SPI_CLK, SPI_CSN and SPI_SDI (minimum 2).
- BW_RATE_RST, 8'h0A, reset value of register 0x2C.

Ports:
- clk  in  1  system clock; must be at least 8x the SPI_CLK frequency.
- rst  in  1  asynchronous, active-high reset.
- SPI_CLK  in  1  serial clock from the initiator; idles high.
- SPI_CSN  in  1  chip select, active low.
- SPI_SDI  in  1  serial data from the initiator.
- SPI_SDO  out  1  serial data to the initiator.
- sample_valid  in  1  one-cycle strobe that loads sample_x, sample_y and sample_z.
- sample_x  in  16  X sample; low byte goes to 0x32, high byte to 0x33.
- sample_y  in  16  Y sample; low byte goes to 0x34, high byte to 0x35.
- sample_z  in  16  Z sample; low byte goes to 0x36, high byte to 0x37.
- wr_valid  out  1  one-cycle pulse when a register write commits.
- wr_addr  out  6  address of the committed write.
- wr_data  out  8  data of the committed write.
- data_ready  out  1  mirrors INT_SOURCE bit 7.
- busy  out  1  high while synchronised CSN is low.

Behaviour:
- Reset values: SPI_SDO=1, wr_valid=0, wr_addr=0, wr_data=0, data_ready=0, busy=0, bit counter=0, shift registers=0.
- Reset register contents: all writable registers 0x00, except 0x2C = BW_RATE_RST. Data registers 0x32-0x37 are 0x00.
- Edge detection:
  - Each SPI input passes through SYNC_STAGES flops.
  - SCLK rise/fall is detected from the last two synchronised samples.
  - Edges are acted on only while synchronised CSN = 0.
- Frame format, MSB first: bit15 = R/nW, bit14 = MB, bits13:8 = address, bits7:0 = data.
- States: IDLE, CMD, WDATA, RDATA, DONE.
- IDLE -> CMD on CSN falling.
- CMD:
  - SDI is shifted in on each SCLK rise.
  - After the 8th rise, latch rw, mb and addr.
  - Read: look up the register value, load the tx shift register, go to RDATA.
  - Write: go to WDATA.
- RDATA:
  - On each SCLK fall, SPI_SDO <= tx[7], then shift left.
  - The first data bit is driven on the fall following the 8th rise.
  - After 8 data bits, go to DONE.
- WDATA:
  - Shift in 8 bits on SCLK rises.
  - On the 16th rise, if addr is writable, write the register and pulse wr_valid one cycle with wr_addr/wr_data. wr_valid asserts 1 clk after the synchronised edge is detected.
  - Go to DONE.
- DONE: ignore further SCLK edges, SDO=1, wait for CSN rising.
- CSN rising in any state:
  - Return to IDLE, SDO=1, clear the counter.
  - A partial frame (fewer than 16 rises) commits nothing and produces no wr_valid.
- Writable addresses: 0x1D-0x2F and 0x31.
- Read-only addresses:
  - 0x00 returns DEVID.
  - 0x30 returns {data_ready, 7'b0}.
  - 0x32-0x37 return sample bytes.
  - All others return 0x00.
- Writes to read-only or reserved addresses are discarded, with no wr_valid.
- Reading 0x30 clears data_ready at the end of the frame, on CSN rising.
- sample_valid handling:
  - With CSN high: load all six bytes next clk and set data_ready.
  - With CSN low: latch into a pending buffer, apply on CSN rising. This prevents a tear within a transaction.
  - A second sample_valid while pending overwrites the pending buffer.
  - Set and clear of data_ready on the same CSN rising: set wins.
- Counter: 5-bit; saturates at 16 in non-burst mode.

Optional Feature:
- Macro: ADXL345_SPI_RESP_BURST_EN.
- Defined:
  - When MB=1, after each 8 data bits addr increments (0x3F wraps to 0x00) and the transfer continues while CSN stays low.
  - Reads reload tx from the new address.
  - Writes commit each byte with its own wr_valid pulse.
  - The pending-sample rule applies until CSN rises.
- Undefined: MB is ignored; the block goes to DONE after 16 bits and SDO stays 1 for extra clocks.

Test Plan:
- Read DEVID: frame 0x80,0x00 -> SDO returns 0xE5 and wr_valid stays 0.
- Write/readback: write 0x2D=0x08 -> one wr_valid pulse with wr_addr=0x2D, wr_data=0x08; then read 0x2D -> 0x08. Write 0x32=0xAA -> no pulse, and 0x32 is unchanged.
- Sample load: sample_valid with x=0x1234, y=0xABCD, z=0x00FF -> reads of 0x32..0x37 return 34,12,CD,AB,FF,00; data_ready=1. Reading 0x30 returns 0x80, then data_ready=0.
- Mid-frame sample: sample_valid during a read of 0x33 -> the old byte is returned; the new value is visible after CSN rises.
- Abort: CSN raised after 12 bits of a write to 0x2C -> no wr_valid, 0x2C still 0x0A.
- Reset mid-frame: rst asserted during RDATA -> SDO=1, state IDLE, registers back to reset values. With burst enabled, read 0xF2 for 6 bytes -> X/Y/Z bytes in order.
